fsm_share_arbiter: RTL
======================

Name: fsm_share_arbiter

Overview:
Round-robin arbiter that shares one fsm core (inputs a/b, outputs y0/y1) among N_REQ requesters. Each requester raises req, receives a one-hot grant, and drives a/b to the core for up to MAX_HOLD cycles. Core outputs are routed back to the granted requester only. Sits between the requester blocks and the single fsm instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_HOLD, 8, maximum cycles a grant is held before forced release (>=2)
ID_W, 2, width of gnt_id; equals clog2(N_REQ)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester request, level
done  input  N_REQ  per-requester release; sampled only for the granted index
a_in  input  N_REQ  per-requester a stimulus
b_in  input  N_REQ  per-requester b stimulus
core_y0  input  1  y0 from the shared fsm core
core_y1  input  1  y1 from the shared fsm core
core_a  output  1  a to the core
core_b  output  1  b to the core
gnt  output  N_REQ  one-hot grant, registered
gnt_id  output  ID_W  index of the granted requester; valid while busy=1
busy  output  1  high while any grant is held
y0_out  output  N_REQ  core_y0 on the granted bit, 0 elsewhere
y1_out  output  N_REQ  core_y1 on the granted bit, 0 elsewhere
timeout  output  1  one-cycle pulse on forced release at MAX_HOLD

Behaviour:
- Reset (rst=0, async): state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, hold_cnt=0, ptr=N_REQ-1 so the first search starts at index 0. core_a=core_b=0.
- States:
  - IDLE: if any req, grant the first set bit searching ptr+1, ptr+2, ... mod N_REQ. gnt/gnt_id/busy are registered, so grant is visible the cycle after req is sampled. Set ptr to the winner. Go to HOLD with hold_cnt=0.
  - HOLD: core_a=a_in[gnt_id], core_b=b_in[gnt_id] (combinational mux). y*_out is combinational from core_y*. hold_cnt increments each cycle. Release when done[gnt_id]=1, or req[gnt_id]=0, or hold_cnt==MAX_HOLD-1. On forced release (counter limit without done or req drop), timeout=1 for that one cycle. Release goes to GAP.
  - GAP: exactly one cycle. gnt=0, busy=0, core_a=core_b=0. Then IDLE.
- Minimum spacing between grants is 1 GAP cycle plus 1 IDLE cycle. A back-to-back requester sees gnt drop for 2 cycles.
- Outside HOLD: core_a=core_b=0 and y0_out=y1_out=0.
- done/req on non-granted indices are ignored during HOLD.
- done and limit in the same cycle count as a normal release: timeout=0.
- Wrap-around: ptr at N_REQ-1 searches from 0. A single persistent requester is regranted after each GAP.
- Reset mid-HOLD: gnt drops immediately (async). Core inputs go to 0 and the fairness pointer restarts.

Optional Feature:
FSM_ARB_PRIO_EN. When defined, req[0] is high priority: in IDLE it wins whenever set, regardless of ptr, and ptr is not updated by a priority grant. Its hold is still bounded by MAX_HOLD. When undefined, all requesters are pure round-robin.

Decomposition:
- Package fsm_arb_pkg: state encoding (IDLE=2'd0, HOLD=2'd1, GAP=2'd2), a default MAX_HOLD localparam, and a function for the rotating first-set search.
- One sub-module, rr_pick: combinational. Inputs are the req vector and ptr; outputs are winner index and a found flag. It is instantiated once in IDLE-path logic.

Test Plan:
- Reset: hold rst=0 for 10 cycles with req=4'b1111. Then gnt=0, busy=0, core_a=core_b=0. Release rst; the first grant is gnt=4'b0001, gnt_id=0.
- Round-robin: req=4'b1111 held, done pulsed 3 cycles into each grant. Grant order is 0,1,2,3,0 with gnt low exactly 2 cycles between grants.
- Routing: grant requester 2 with a_in[2]=1, b_in[2]=0 and other a_in/b_in=1. Then core_a=1, core_b=0. Force core_y0=1: y0_out=4'b0100.
- Timeout: req=4'b0010 held, done never asserted. timeout pulses once on the 8th HOLD cycle (MAX_HOLD=8). Requester 1 is regranted after GAP+IDLE.
- Req drop: grant index 3, deassert req[3] mid-hold. Release occurs next cycle with timeout=0. A pending req[0] is granted 2 cycles later.
- FSM_ARB_PRIO_EN: ptr=0, req=4'b0011 -> gnt=4'b0001 repeatedly. Without the macro, the grant alternates 0,1.

Source files
------------

// File: rtl/fsm_arb_pkg.sv
// Shared types and helpers for the fsm_share_arbiter slice: state encoding,
// default hold limit and the rotating first-set search used by rr_pick.
package fsm_arb_pkg;

    localparam int MAX_REQ          = 8;
    localparam int DEFAULT_MAX_HOLD = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set bit of req[n-1:0] scanning ptr+1, ptr+2, ... modulo n.
    function automatic pick_t rr_search(input logic [MAX_REQ-1:0] req,
                                        input logic [2:0]         ptr,
                                        input int                 n);
        pick_t res;
        int    cand;
        res.found = 1'b0;
        res.idx   = 3'd0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            cand = (int'(ptr) + k) % n;
            if ((k <= n) && !res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand[2:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fsm_share_arbiter_rr_pick.sv
// Combinational rotating-priority picker: returns the first requester after
// ptr (wrapping) and whether any requester was found.
module rr_pick
    import fsm_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  winner,
    output logic             found
);

    logic [MAX_REQ-1:0] req_ext_s;
    logic [2:0]         ptr_ext_s;
    pick_t              pick_s;
    logic               pick_unused_s;

    // Widen the request vector and pointer to the package search width.
    always_comb begin
        req_ext_s              = {MAX_REQ{1'b0}};
        req_ext_s[N_REQ-1:0]   = req;
        ptr_ext_s              = 3'd0;
        ptr_ext_s[ID_W-1:0]    = ptr;
    end

    // Run the search and narrow the winner back to the id width.
    always_comb begin
        pick_s        = rr_search(req_ext_s, ptr_ext_s, N_REQ);
        winner        = pick_s.idx[ID_W-1:0];
        found         = pick_s.found;
        pick_unused_s = ^pick_s.idx;
    end

endmodule

// File: rtl/fsm_share_arbiter.sv
// Round-robin arbiter sharing one fsm core among N_REQ requesters.
// Optional build macro FSM_ARB_PRIO_EN makes req[0] a high-priority requester.
module fsm_share_arbiter
    import fsm_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    input  logic [N_REQ-1:0] a_in,
    input  logic [N_REQ-1:0] b_in,
    input  logic             core_y0,
    input  logic             core_y1,
    output logic             core_a,
    output logic             core_b,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic [N_REQ-1:0] y0_out,
    output logic [N_REQ-1:0] y1_out,
    output logic             timeout
);

    localparam int               CNT_W        = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
    localparam logic [N_REQ-1:0] ONE_HOT_BASE = N_REQ'(1'b1);
    localparam logic [ID_W-1:0]  PTR_RESET    = ID_W'(N_REQ - 1);

    arb_state_e        state_r, state_s;
    logic [N_REQ-1:0]  gnt_r, gnt_s;
    logic [ID_W-1:0]   gnt_id_r, gnt_id_s;
    logic              busy_r, busy_s;
    logic [CNT_W-1:0]  hold_cnt_r, hold_cnt_s;
    logic [ID_W-1:0]   ptr_r, ptr_s;
    logic              timeout_s;
    logic              core_a_s, core_b_s;
    logic [ID_W-1:0]   win_s;
    logic              found_s;
    logic              prio_hit_s;
    logic              own_req_s, own_done_s, at_limit_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_r),
        .winner (win_s),
        .found  (found_s)
    );

    // Priority override for requester 0 when the option is built in.
    always_comb begin
`ifdef FSM_ARB_PRIO_EN
        prio_hit_s = req[0];
`else
        prio_hit_s = 1'b0;
`endif
    end

    // Release conditions seen only through the currently granted index.
    always_comb begin
        own_req_s  = req[gnt_id_r];
        own_done_s = done[gnt_id_r];
        at_limit_s = (hold_cnt_r == HOLD_LAST);
    end

    // Next-state, next-grant and core-side outputs.
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt_r;
        gnt_id_s   = gnt_id_r;
        busy_s     = busy_r;
        hold_cnt_s = hold_cnt_r;
        ptr_s      = ptr_r;
        timeout_s  = 1'b0;
        core_a_s   = 1'b0;
        core_b_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (prio_hit_s) begin
                    // Priority grants leave the fairness pointer untouched.
                    state_s    = HOLD;
                    gnt_s      = ONE_HOT_BASE;
                    gnt_id_s   = {ID_W{1'b0}};
                    busy_s     = 1'b1;
                    hold_cnt_s = {CNT_W{1'b0}};
                end else if (found_s) begin
                    state_s    = HOLD;
                    gnt_s      = ONE_HOT_BASE << win_s;
                    gnt_id_s   = win_s;
                    busy_s     = 1'b1;
                    hold_cnt_s = {CNT_W{1'b0}};
                    ptr_s      = win_s;
                end else begin
                    state_s    = IDLE;
                end
            end
            HOLD: begin
                core_a_s = a_in[gnt_id_r];
                core_b_s = b_in[gnt_id_r];
                if (own_done_s || !own_req_s || at_limit_s) begin
                    state_s    = GAP;
                    gnt_s      = {N_REQ{1'b0}};
                    busy_s     = 1'b0;
                    hold_cnt_s = {CNT_W{1'b0}};
                    timeout_s  = at_limit_s && own_req_s && !own_done_s;
                end else begin
                    hold_cnt_s = hold_cnt_r + CNT_ONE;
                end
            end
            GAP: begin
                state_s = IDLE;
                gnt_s   = {N_REQ{1'b0}};
                busy_s  = 1'b0;
            end
            default: begin
                state_s    = IDLE;
                gnt_s      = {N_REQ{1'b0}};
                busy_s     = 1'b0;
                hold_cnt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and grant registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            gnt_r      <= {N_REQ{1'b0}};
            gnt_id_r   <= {ID_W{1'b0}};
            busy_r     <= 1'b0;
            hold_cnt_r <= {CNT_W{1'b0}};
            ptr_r      <= PTR_RESET;
        end else begin
            state_r    <= state_s;
            gnt_r      <= gnt_s;
            gnt_id_r   <= gnt_id_s;
            busy_r     <= busy_s;
            hold_cnt_r <= hold_cnt_s;
            ptr_r      <= ptr_s;
        end
    end

    // Core results are steered to the granted requester only.
    always_comb begin
        if (state_r == HOLD) begin
            y0_out = gnt_r & {N_REQ{core_y0}};
            y1_out = gnt_r & {N_REQ{core_y1}};
        end else begin
            y0_out = {N_REQ{1'b0}};
            y1_out = {N_REQ{1'b0}};
        end
    end

    assign gnt     = gnt_r;
    assign gnt_id  = gnt_id_r;
    assign busy    = busy_r;
    assign core_a  = core_a_s;
    assign core_b  = core_b_s;
    assign timeout = timeout_s;

endmodule
